// File: rtl/shaman_nibble_bridge_pkg.sv
// Shared types and sizing helpers for the shaman pin-side nibble bridge.
// Optional feature macro used by the bridge: SHAMAN_BRIDGE_OVF_EN.
package shaman_pkg;

    localparam int NIB_W_DEF      = 4;
    localparam int WORD_W_DEF     = 32;
    localparam int DIGEST_W_DEF   = 256;
    localparam int FIFO_DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHOW
    } out_state_t;

    function automatic int nibs_per_word(input int word_w, input int nib_w);
        return word_w / nib_w;
    endfunction

    function automatic int nibs_per_digest(input int digest_w, input int nib_w);
        return digest_w / nib_w;
    endfunction

    // Width of a counter that must hold values 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef logic [$clog2(WORD_W_DEF / NIB_W_DEF)-1:0]   word_nib_cnt_t;
    typedef logic [$clog2(DIGEST_W_DEF / NIB_W_DEF)-1:0] digest_nib_idx_t;

endpackage

// File: rtl/shaman_sync_fifo.sv
// Synchronous first-word fall-through FIFO with occupancy count.
// Simultaneous push and pop is accepted at any level, including full.
module shaman_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic                   head_valid,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             pop_ok;
    logic             push_ok;

    assign full       = (count == CNT_W'(DEPTH));
    assign head_valid = (count != '0);
    assign pop_ok     = pop & head_valid;
    // When full, a push only lands if the head leaves in the same cycle.
    assign push_ok    = push & (~full | pop_ok);
    assign head_data  = head_valid ? mem[rd_ptr] : '0;

    // NOTE: storage has no reset; only pointers and count are reset, and the
    // head is masked while empty, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/shaman_nibble_bridge.sv
// Pin-side bridge for the shaman hash core: packs host nibbles into FIFO'd core words and
// streams the digest back one nibble per host strobe. Optional macro: SHAMAN_BRIDGE_OVF_EN.
module shaman_nibble_bridge
    import shaman_pkg::*;
#(
    parameter int NIB_W      = NIB_W_DEF,
    parameter int WORD_W     = WORD_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int DIGEST_W   = DIGEST_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_strobe,
    input  logic [NIB_W-1:0]    in_nibble,
    input  logic                result_req,
    output logic [NIB_W-1:0]    out_nibble,
    output logic                busy,
    output logic                word_valid,
    output logic [WORD_W-1:0]   word_data,
    input  logic                word_ready,
    input  logic                digest_valid,
    input  logic [DIGEST_W-1:0] digest,
    output logic                digest_ack
`ifdef SHAMAN_BRIDGE_OVF_EN
    ,
    output logic                overflow
`endif
);

    localparam int NPW   = nibs_per_word(WORD_W, NIB_W);
    localparam int NPD   = nibs_per_digest(DIGEST_W, NIB_W);
    localparam int CW    = cnt_w(NPW);
    localparam int IW    = cnt_w(NPD);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CW-1:0]    NIB_LAST  = CW'(NPW - 1);
    localparam logic [IW-1:0]    IDX_LAST  = IW'(NPD - 1);
    localparam logic [CNT_W-1:0] BUSY_LVL  = CNT_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_LVL  = CNT_W'(FIFO_DEPTH);

    // Strobe synchronisers and edge detection
    logic             in_s, in_prev, res_s, res_prev;
    logic [NIB_W-1:0] nib_q;
    logic             in_edge, res_edge;

    // Packer
    logic [WORD_W-1:0] pack_sr;
    logic [WORD_W-1:0] pack_next;
    logic [CW-1:0]     nib_cnt;
    logic              push;

    logic [CNT_W-1:0]  fifo_count;
    logic              busy_q;

    // Digest output FSM
    out_state_t        state_q, state_d;
    logic [DIGEST_W-1:0] dig_sr_q, dig_sr_d;
    logic [IW-1:0]     idx_q, idx_d;

    assign in_edge   = in_s & ~in_prev;
    assign res_edge  = res_s & ~res_prev;
    assign pack_next = {pack_sr[WORD_W-NIB_W-1:0], nib_q};
    assign push      = in_edge && (nib_cnt == NIB_LAST);

    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_s     <= 1'b0;
            in_prev  <= 1'b0;
            res_s    <= 1'b0;
            res_prev <= 1'b0;
            nib_q    <= '0;
            pack_sr  <= '0;
            nib_cnt  <= '0;
        end else begin
            in_s     <= in_strobe;
            in_prev  <= in_s;
            res_s    <= result_req;
            res_prev <= res_s;
            nib_q    <= in_nibble;
            if (in_edge) begin
                pack_sr <= pack_next;
                nib_cnt <= (nib_cnt == NIB_LAST) ? '0 : nib_cnt + 1'b1;
            end
        end
    end

    shaman_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (pack_next),
        .pop        (word_ready),
        .head_valid (word_valid),
        .head_data  (word_data),
        .count      (fifo_count)
    );

`ifdef SHAMAN_BRIDGE_OVF_EN
    logic overflow_q;
    logic drop;

    // A push into a full FIFO is lost unless the head leaves in the same cycle.
    assign drop     = push && (fifo_count == FULL_LVL) && !(word_valid && word_ready);
    assign overflow = overflow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            if (drop) begin
                overflow_q <= 1'b1;
            end
            busy_q <= (fifo_count >= BUSY_LVL) || (state_q == LOAD) || overflow_q;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= (fifo_count >= BUSY_LVL) || (state_q == LOAD);
        end
    end
`endif

    assign busy = busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            dig_sr_q <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            dig_sr_q <= dig_sr_d;
            idx_q    <= idx_d;
        end
    end

    // NOTE: every output of this block is defaulted first, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        dig_sr_d = dig_sr_q;
        idx_d    = idx_q;
        case (state_q)
            IDLE: begin
                if (digest_valid) begin
                    state_d  = LOAD;
                    dig_sr_d = digest;
                    idx_d    = '0;
                end
            end
            LOAD: begin
                state_d = SHOW;
            end
            SHOW: begin
                if (res_edge) begin
                    if (idx_q != IDX_LAST) begin
                        dig_sr_d = {dig_sr_q[DIGEST_W-NIB_W-1:0], {NIB_W{1'b0}}};
                        idx_d    = idx_q + 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Both outputs decode registered state only, so they are glitch-free to the pins.
    assign out_nibble = (state_q == SHOW) ? dig_sr_q[DIGEST_W-1 -: NIB_W] : '0;
    assign digest_ack = (state_q == LOAD);

endmodule
